// File: rtl/ps_node_endpoint.sv
// ps_node_endpoint
//   Register endpoint hanging off the PS distribution core. Accepts one
//   request at a time, decodes it against NODE_ID, and answers matching
//   requests with a single response. Requests for other nodes are
//   swallowed without a response.
//
//   Register map:
//     0 CTRL   : write-only pulses. wdata[0] -> ctrl_start, wdata[1] -> ctrl_clear.
//                Reads return 0.
//     1 STATUS : read-only. Returns status_in. A write is an error.
//     2..N-1   : read/write config registers, exported on cfg_out.
//
//   Ports:
//     clk, rst_n                 clock, synchronous active-low reset
//     req_valid/req_ready        request handshake (ready only while idle)
//     req_node_addr, req_write,
//     req_reg_addr, req_wdata    request fields, captured on acceptance
//     rsp_valid/rsp_ready        response handshake
//     rsp_rdata, rsp_err         response payload, held until rsp_ready
//     status_in                  value returned by register 1
//     cfg_out                    register k on [k*DATA_WIDTH +: DATA_WIDTH]
//     ctrl_start, ctrl_clear     single-cycle pulses from CTRL writes
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | ready for a request; non-matching node addresses dropped here
//   EXEC  | one cycle; access performed on the closing edge
//   RESP  | response presented until rsp_ready

module ps_node_endpoint #(
  parameter int NODE_ID     = 0,
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_REGS    = 8,
  parameter int NODE_ADDR_W = 4,
  parameter int REG_ADDR_W  = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic [NODE_ADDR_W-1:0]         req_node_addr,
  input  logic                           req_write,
  input  logic [REG_ADDR_W-1:0]          req_reg_addr,
  input  logic [DATA_WIDTH-1:0]          req_wdata,
  output logic                           rsp_valid,
  input  logic                           rsp_ready,
  output logic [DATA_WIDTH-1:0]          rsp_rdata,
  output logic                           rsp_err,
  input  logic [DATA_WIDTH-1:0]          status_in,
  output logic [NUM_REGS*DATA_WIDTH-1:0] cfg_out,
  output logic                           ctrl_start,
  output logic                           ctrl_clear
);

  localparam logic [31:0] NUM_REGS_U = 32'(NUM_REGS);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e                  state_q;
  logic                    req_ready_q;
  logic                    rsp_valid_q;
  logic                    rsp_err_q;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q;
  logic                    ctrl_start_q;
  logic                    ctrl_clear_q;

  logic                    write_q;
  logic [REG_ADDR_W-1:0]   reg_addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;

  // Only the writable registers have storage; 0 and 1 are not state.
  logic [DATA_WIDTH-1:0]   cfg_q [2:NUM_REGS-1];

  logic                    node_hit;
  logic [31:0]             reg_idx;
  logic [DATA_WIDTH-1:0]   rsp_rdata_d;
  logic                    rsp_err_d;

  assign node_hit = (req_node_addr == NODE_ADDR_W'(NODE_ID));
  assign reg_idx  = 32'(reg_addr_q);

  // Response payload for the captured request; consumed on the EXEC edge,
  // so status_in is sampled exactly there.
  always_comb begin
    rsp_rdata_d = '0;
    rsp_err_d   = 1'b0;
    if (reg_idx >= NUM_REGS_U) begin
      rsp_err_d = 1'b1;
    end else if (write_q) begin
      rsp_err_d = (reg_idx == 32'd1);
    end else begin
      if (reg_idx == 32'd1) begin
        rsp_rdata_d = status_in;
      end
      for (int k = 2; k < NUM_REGS; k++) begin
        if (reg_idx == 32'(k)) begin
          rsp_rdata_d = cfg_q[k];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      req_ready_q  <= 1'b1;
      rsp_valid_q  <= 1'b0;
      rsp_err_q    <= 1'b0;
      rsp_rdata_q  <= '0;
      ctrl_start_q <= 1'b0;
      ctrl_clear_q <= 1'b0;
      write_q      <= 1'b0;
      reg_addr_q   <= '0;
      wdata_q      <= '0;
      for (int k = 2; k < NUM_REGS; k++) begin
        cfg_q[k] <= '0;
      end
    end else begin
      ctrl_start_q <= 1'b0;
      ctrl_clear_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            write_q    <= req_write;
            reg_addr_q <= req_reg_addr;
            wdata_q    <= req_wdata;
            // Foreign node: the handshake completes but nothing else happens.
            if (node_hit) begin
              state_q     <= ST_EXEC;
              req_ready_q <= 1'b0;
            end
          end
        end
        ST_EXEC: begin
          state_q     <= ST_RESP;
          rsp_valid_q <= 1'b1;
          rsp_rdata_q <= rsp_rdata_d;
          rsp_err_q   <= rsp_err_d;
          if (write_q && !rsp_err_d) begin
            if (reg_idx == 32'd0) begin
              ctrl_start_q <= wdata_q[0];
              ctrl_clear_q <= wdata_q[1];
            end
            for (int k = 2; k < NUM_REGS; k++) begin
              if (reg_idx == 32'(k)) begin
                cfg_q[k] <= wdata_q;
              end
            end
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            state_q     <= ST_IDLE;
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          rsp_valid_q <= 1'b0;
          req_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready  = req_ready_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_rdata  = rsp_rdata_q;
  assign rsp_err    = rsp_err_q;
  assign ctrl_start = ctrl_start_q;
  assign ctrl_clear = ctrl_clear_q;

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_cfg
    if (g < 2) begin : g_zero
      assign cfg_out[g*DATA_WIDTH +: DATA_WIDTH] = '0;
    end else begin : g_reg
      assign cfg_out[g*DATA_WIDTH +: DATA_WIDTH] = cfg_q[g];
    end
  end

endmodule

// File: doc/ps_node_endpoint.md
PS_NODE_ENDPOINT -- requirements
Module: ps_node_endpoint

Interface
REQ-001 SHALL have parameter NODE_ID, default 0: node address this endpoint answers to.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: register and data width.
REQ-003 SHALL have parameter NUM_REGS, default 8, minimum 3: register count.
REQ-004 SHALL have parameter NODE_ADDR_W, default 4, and parameter REG_ADDR_W, default 4: address field widths.
REQ-005 SHALL have port clk, input, 1: clock; all logic on posedge.
REQ-006 SHALL have port rst_n, input, 1: reset, synchronous, active-low.
REQ-007 SHALL have port req_valid, input, 1: request present from the PS distribution core.
REQ-008 SHALL have port req_ready, output, 1: endpoint accepts a request.
REQ-009 SHALL have port req_node_addr, input, NODE_ADDR_W: destination node.
REQ-010 SHALL have port req_write, input, 1: 1 = write, 0 = read.
REQ-011 SHALL have port req_reg_addr, input, REG_ADDR_W: register index.
REQ-012 SHALL have port req_wdata, input, DATA_WIDTH: write data.
REQ-013 SHALL have port rsp_valid, output, 1: response present towards the arbiter.
REQ-014 SHALL have port rsp_ready, input, 1: arbiter accepts the response.
REQ-015 SHALL have port rsp_rdata, output, DATA_WIDTH: read data, or 0 for writes and errors.
REQ-016 SHALL have port rsp_err, output, 1: illegal access.
REQ-017 SHALL have port status_in, input, DATA_WIDTH: value returned by reg 1.
REQ-018 SHALL have port cfg_out, output, NUM_REGS*DATA_WIDTH: reg k on bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-019 SHALL have ports ctrl_start and ctrl_clear, output, 1 each: single-cycle pulses.

Function
REQ-020 SHALL implement an FSM with states IDLE, EXEC and RESP; req_ready SHALL be 1 only in IDLE.
REQ-021 SHALL accept a request in IDLE on an edge with req_valid=1; at acceptance, all req_* fields SHALL be captured.
REQ-022 On acceptance with req_node_addr != NODE_ID, the request SHALL be dropped silently: no response, no register change, FSM stays IDLE.
REQ-023 On acceptance with req_node_addr == NODE_ID, the FSM SHALL go to EXEC.
REQ-024 EXEC SHALL last exactly one cycle; at its closing edge the FSM SHALL perform the access, load rsp_rdata/rsp_err, and go to RESP.
REQ-025 rsp_valid SHALL be 1 only in RESP, asserted 2 cycles after the accepting edge.
REQ-026 In RESP, rsp_rdata and rsp_err SHALL be held stable until an edge with rsp_ready=1; that edge SHALL return the FSM to IDLE.
REQ-027 Reg 0 (CTRL) write SHALL pulse ctrl_start if wdata[0]=1 and ctrl_clear if wdata[1]=1, for the one cycle following the EXEC edge; reg 0 SHALL read as 0.
REQ-028 Reg 1 (STATUS) reads SHALL return status_in as sampled at the EXEC edge; a write to reg 1 SHALL set rsp_err=1 and change nothing.
REQ-029 Regs 2..NUM_REGS-1 SHALL be read/write; the written value SHALL appear on cfg_out from the cycle after the EXEC edge.
REQ-030 cfg_out slices for regs 0 and 1 SHALL be 0.
REQ-031 req_reg_addr >= NUM_REGS SHALL set rsp_err=1 and rsp_rdata=0, with no register change.
REQ-032 ctrl_clear SHALL NOT modify config registers; its meaning is owned by the consumer.
REQ-033 A new request SHALL NOT be accepted while in EXEC or RESP; the upstream holds it, with no loss.

Reset
REQ-034 With rst_n=0 at a clock edge: FSM = IDLE; req_ready=1 on the following cycle; rsp_valid=0; rsp_rdata=0; rsp_err=0; ctrl_start=0; ctrl_clear=0; all config registers = 0.
REQ-035 Reset during EXEC or RESP SHALL abort the transaction; no response SHALL be emitted after reset.

Verification
REQ-036 NODE_ID=2: write node 2, reg 3, 0xDEADBEEF -> rsp_valid 2 cycles later; rsp_err=0; rsp_rdata=0; cfg_out[127:96]=0xDEADBEEF; a read of reg 3 then returns 0xDEADBEEF.
REQ-037 Request to node 1 while NODE_ID=2 -> accepted in 1 cycle; no rsp_valid for 10 cycles; cfg_out unchanged.
REQ-038 Write reg 0 = 0x3 -> ctrl_start and ctrl_clear each high exactly 1 cycle; read reg 0 returns 0.
REQ-039 Set status_in=0x55, read reg 1 -> rdata 0x55; write reg 1 -> rsp_err=1; read reg 9 (NUM_REGS=8) -> rsp_err=1, rdata 0.
REQ-040 Hold rsp_ready=0 for 5 cycles with a second req_valid pending -> response stable, req_ready=0; rsp_ready=1 -> IDLE; second request accepted the next cycle.
REQ-041 Assert rst_n=0 during RESP -> rsp_valid=0 the next cycle; config registers cleared to 0.
